// File: rtl/mac_tx_framer.sv
// Store-and-forward MAC transmit framer: buffers whole frames, pads short ones, enforces inter-frame gap.
// Latency: a frame's last word written in cycle N raises tx_data_valid in cycle N+2 (from IDLE).
// Backpressure: none upstream (full/overflow flags only; writes while full are dropped); MAC paces byte 0 via tx_ack.
//
// Ports:
//   tx_clk, tx_reset             single clock, synchronous active-high reset
//   wr_data/wr_last/wr_en        write side: data word, end-of-frame flag, strobe
//   full, count, overflow        FIFO status (registered), sticky overflow/deadlock flag
//   tx_data, tx_data_valid       MAC client data and frame-in-progress strobe
//   tx_ack                       MAC accepted byte 0 (only observed while waiting for it)
//   frames_sent                  completed-frame counter, wraps at 2^16
module mac_tx_framer #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 9,
    parameter int MIN_FRAME  = 60,
    parameter int IFG        = 12
) (
    input  logic                  tx_clk,
    input  logic                  tx_reset,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_last,
    input  logic                  wr_en,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [DATA_W-1:0]     tx_data,
    output logic                  tx_data_valid,
    input  logic                  tx_ack,
    output logic [15:0]           frames_sent
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [16:0]       MIN_LEN  = 17'(MIN_FRAME);
    localparam logic [7:0]        IFG_LEN  = 8'(IFG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACK,
        S_SEND,
        S_PAD,
        S_GAP
    } state_t;

    // Each entry holds {last, data}.
    logic [DATA_W:0]         mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic [DEPTH_LOG2:0]     pending_q, pending_d;
    logic                    full_q, full_d;
    logic                    overflow_q, overflow_d;
    state_t                  state_q, state_d;
    logic [15:0]             byte_cnt_q, byte_cnt_d;
    logic [15:0]             frames_q, frames_d;
    logic [7:0]              gap_cnt_q, gap_cnt_d;

    logic                    wr_acc;
    logic                    pop;
    logic                    flush;
    logic                    head_last;
    logic [DATA_W-1:0]       head_data;
    logic [15:0]             byte_inc;
    logic [16:0]             bytes_after;
    logic                    tx_valid_c;
    logic [DATA_W-1:0]       tx_data_c;

    // First-word-fall-through: the head word is read combinationally.
    assign head_data = mem_q[rd_ptr_q][DATA_W-1:0];
    assign head_last = mem_q[rd_ptr_q][DATA_W];

    assign wr_acc = wr_en & ~full_q;
    // A full FIFO holding no complete frame can never drain: discard it.
    assign flush  = full_q && (pending_q == '0);

    // Byte counter saturates; bytes_after is the unsaturated count including
    // the byte driven this cycle, used for the pad decision.
    assign byte_inc    = (byte_cnt_q == 16'hFFFF) ? 16'hFFFF : byte_cnt_q + 16'd1;
    assign bytes_after = {1'b0, byte_cnt_q} + 17'd1;

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_valid_c = 1'b0;
        tx_data_c  = '0;

        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                tx_valid_c = 1'b1;
                tx_data_c  = head_data;
                if (tx_ack) begin
                    pop        = 1'b1;
                    byte_cnt_d = 16'd1;
                    if (head_last) begin
                        state_d = (17'd1 < MIN_LEN) ? S_PAD : S_GAP;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                tx_valid_c = 1'b1;
                tx_data_c  = head_data;
                pop        = 1'b1;
                byte_cnt_d = byte_inc;
                if (head_last) begin
                    state_d = (bytes_after < MIN_LEN) ? S_PAD : S_GAP;
                end
            end
            S_PAD: begin
                tx_valid_c = 1'b1;
                byte_cnt_d = byte_inc;
                if (bytes_after >= MIN_LEN) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // Occupies IFG+1 cycles in total.
                if (gap_cnt_q == IFG_LEN) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_GAP && state_q != S_GAP) begin
            gap_cnt_d = 8'd0;
        end

        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(wr_acc);
        rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(pop);
        count_d    = count_q + (DEPTH_LOG2+1)'(wr_acc) - (DEPTH_LOG2+1)'(pop);
        // Simultaneous frame-in and frame-out cancel out.
        pending_d  = pending_q + (DEPTH_LOG2+1)'(wr_acc & wr_last)
                               - (DEPTH_LOG2+1)'(pop & head_last);
        overflow_d = overflow_q | (wr_en & full_q) | flush;
        frames_d   = frames_q;
        if (state_d == S_GAP && state_q != S_GAP) begin
            frames_d = frames_q + 16'd1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        full_d = (count_d == FULL_LVL);
    end

    always_ff @(posedge tx_clk) begin
        if (tx_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            frames_q   <= '0;
            gap_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            frames_q   <= frames_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge tx_clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= {wr_last, wr_data};
        end
    end

    assign full          = full_q;
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign tx_data       = tx_data_c;
    assign tx_data_valid = tx_valid_c;
    assign frames_sent   = frames_q;

endmodule

// File: tb/tb_mac_tx_framer.sv
// Testbench for mac_tx_framer: frame-level reference model (padded byte streams, gap lengths, FIFO occupancy).
// Inputs are driven and outputs sampled at the falling edge.
// Two instances: default depth for framing tests, depth 16 for the overflow/deadlock case.
module tb_mac_tx_framer;

    localparam int MIN_FRAME = 60;
    localparam int IFG       = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        tx_reset;
    logic [7:0]  wr_data;
    logic        wr_last, wr_en, tx_ack;
    logic        full, overflow, tx_data_valid;
    logic [9:0]  count;
    logic [7:0]  tx_data;
    logic [15:0] frames_sent;

    logic [7:0]  s_wr_data;
    logic        s_wr_last, s_wr_en, s_tx_ack;
    logic        s_full, s_overflow, s_tx_data_valid;
    logic [4:0]  s_count;
    logic [7:0]  s_tx_data;
    logic [15:0] s_frames_sent;

    mac_tx_framer #(.DATA_W(8), .DEPTH_LOG2(9), .MIN_FRAME(MIN_FRAME), .IFG(IFG)) dut (
        .tx_clk(clk), .tx_reset(tx_reset), .wr_data(wr_data), .wr_last(wr_last), .wr_en(wr_en),
        .full(full), .count(count), .overflow(overflow), .tx_data(tx_data),
        .tx_data_valid(tx_data_valid), .tx_ack(tx_ack), .frames_sent(frames_sent));

    mac_tx_framer #(.DATA_W(8), .DEPTH_LOG2(4), .MIN_FRAME(MIN_FRAME), .IFG(IFG)) dut_small (
        .tx_clk(clk), .tx_reset(tx_reset), .wr_data(s_wr_data), .wr_last(s_wr_last), .wr_en(s_wr_en),
        .full(s_full), .count(s_count), .overflow(s_overflow), .tx_data(s_tx_data),
        .tx_data_valid(s_tx_data_valid), .tx_ack(s_tx_ack), .frames_sent(s_frames_sent));

    int         n_checks = 0;
    int         n_pass   = 0;
    int         exp_frames = 0;
    logic [7:0] exp_q[$];
    int         exp_len_q[$];
    logic [7:0] cap_q[$];
    int         hold_bad;
    bit         timed_out;

    // Model: a frame of L bytes goes out as its bytes followed by zeros up to MIN_FRAME.
    task automatic write_frame(input int len, input bit seq);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = seq ? 8'(i) : 8'($urandom);
            wr_en = 1'b1; wr_data = b; wr_last = (i == len - 1);
            exp_q.push_back(b);
            @(negedge clk);
        end
        wr_en = 1'b0; wr_last = 1'b0; wr_data = 8'h00;
        for (int i = len; i < MIN_FRAME; i++) exp_q.push_back(8'h00);
        exp_len_q.push_back(len < MIN_FRAME ? MIN_FRAME : len);
    endtask

    // Waits for valid, holds off ack for ack_dly cycles, then captures bytes until valid drops.
    // Random tx_ack after byte 0 must be ignored. Returns at the first low cycle.
    task automatic collect(input int ack_dly);
        int n;
        cap_q.delete(); hold_bad = 0; timed_out = 0;
        n = 0;
        while (tx_data_valid !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        if (tx_data_valid !== 1'b1) begin timed_out = 1; return; end
        for (int d = 0; d < ack_dly; d++) begin
            if (tx_data_valid !== 1'b1 || exp_q.size() == 0 || tx_data !== exp_q[0]) hold_bad++;
            @(negedge clk);
        end
        tx_ack = 1'b1;
        n = 0;
        while (tx_data_valid === 1'b1 && n < 2000) begin
            cap_q.push_back(tx_data);
            @(negedge clk);
            tx_ack = 1'($urandom);
            n++;
        end
        tx_ack = 1'b0;
        if (n >= 2000) timed_out = 1;
    endtask

    // Pops the model's next frame and counts byte differences against the capture.
    task automatic score_frame(output int exp_len, output int bad);
        logic [7:0] e;
        exp_len = (exp_len_q.size() != 0) ? exp_len_q.pop_front() : 0;
        bad = 0;
        for (int i = 0; i < exp_len; i++) begin
            e = exp_q.pop_front();
            if (i >= cap_q.size() || cap_q[i] !== e) bad++;
        end
    endtask

    task automatic test_reset();
        tx_reset = 1'b1;
        repeat (2) @(negedge clk);
        tx_reset = 1'b0;
        n_checks++; if (count !== 10'd0) $display("FAIL reset_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else n_pass++;
        n_checks++; if (tx_data_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", tx_data_valid); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", tx_data); else n_pass++;
        n_checks++; if (frames_sent !== 16'd0) $display("FAIL reset_frames got=%0d exp=0", frames_sent); else n_pass++;
    endtask

    task automatic test_frame_64();
        int len, bad, n;
        write_frame(64, 1'b1);
        n_checks++; if (tx_data_valid !== 1'b0) $display("FAIL latency_n1 valid=%b exp=0", tx_data_valid); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (tx_data_valid !== 1'b1 || tx_data !== 8'h00)
            $display("FAIL latency_n2 valid=%b data=%h exp valid=1 data=00", tx_data_valid, tx_data);
        else n_pass++;
        collect(3);
        score_frame(len, bad);
        n_checks++; if (timed_out || hold_bad != 0) $display("FAIL f64_hold timeout=%0d hold_bad=%0d exp 0/0", timed_out, hold_bad); else n_pass++;
        n_checks++; if (cap_q.size() != len) $display("FAIL f64_len got=%0d exp=%0d", cap_q.size(), len); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL f64_bytes mismatches=%0d exp=0", bad); else n_pass++;
        exp_frames++;
        n_checks++; if (frames_sent !== 16'(exp_frames)) $display("FAIL f64_frames got=%0d exp=%0d", frames_sent, exp_frames); else n_pass++;
        n = 0;
        repeat (20) begin if (tx_data_valid !== 1'b0) n++; @(negedge clk); end
        n_checks++; if (n != 0) $display("FAIL f64_gap_low high_cycles=%0d exp=0", n); else n_pass++;
        n_checks++; if (count !== 10'd0) $display("FAIL f64_count got=%0d exp=0", count); else n_pass++;
    endtask

    task automatic test_short(input int flen);
        int len, bad;
        write_frame(flen, 1'b0);
        collect(int'($urandom_range(0, 4)));
        score_frame(len, bad);
        n_checks++; if (timed_out || hold_bad != 0) $display("FAIL short%0d_hold timeout=%0d hold_bad=%0d exp 0/0", flen, timed_out, hold_bad); else n_pass++;
        n_checks++; if (cap_q.size() != len) $display("FAIL short%0d_len got=%0d exp=%0d", flen, cap_q.size(), len); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL short%0d_bytes mismatches=%0d exp=0", flen, bad); else n_pass++;
        exp_frames++;
        n_checks++; if (frames_sent !== 16'(exp_frames)) $display("FAIL short%0d_frames got=%0d exp=%0d", flen, frames_sent, exp_frames); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int len, bad, n;
        for (int f = 0; f < 3; f++) write_frame(int'($urandom_range(1, 100)), 1'b0);
        for (int f = 0; f < 3; f++) begin
            collect(int'($urandom_range(0, 3)));
            score_frame(len, bad);
            n_checks++; if (timed_out || hold_bad != 0) $display("FAIL b2b%0d_hold timeout=%0d hold_bad=%0d exp 0/0", f, timed_out, hold_bad); else n_pass++;
            n_checks++; if (cap_q.size() != len) $display("FAIL b2b%0d_len got=%0d exp=%0d", f, cap_q.size(), len); else n_pass++;
            n_checks++; if (bad != 0) $display("FAIL b2b%0d_bytes mismatches=%0d exp=0", f, bad); else n_pass++;
            exp_frames++;
            n_checks++; if (frames_sent !== 16'(exp_frames)) $display("FAIL b2b%0d_frames got=%0d exp=%0d", f, frames_sent, exp_frames); else n_pass++;
            if (f < 2) begin
                n = 0;
                while (tx_data_valid !== 1'b1 && n < 100) begin n++; @(negedge clk); end
                n_checks++; if (n != IFG + 2) $display("FAIL b2b%0d_gap low_cycles=%0d exp=%0d", f, n, IFG + 2); else n_pass++;
            end
        end
    endtask

    // Frame B's last word is written in the very cycle frame A's last word is popped.
    task automatic test_same_cycle_last();
        int len, bad, n, lb, j;
        logic [7:0] b;
        lb = int'($urandom_range(2, 30));
        write_frame(64, 1'b0);
        n = 0;
        while (tx_data_valid !== 1'b1 && n < 100) begin n++; @(negedge clk); end
        cap_q.delete();
        for (int k = 0; k < 64; k++) begin
            tx_ack = (k == 0);
            if (k >= 64 - lb) begin
                j = k - (64 - lb);
                b = 8'($urandom);
                wr_en = 1'b1; wr_data = b; wr_last = (j == lb - 1);
                exp_q.push_back(b);
            end
            if (tx_data_valid === 1'b1) cap_q.push_back(tx_data);
            @(negedge clk);
        end
        wr_en = 1'b0; wr_last = 1'b0; tx_ack = 1'b0;
        for (int i = lb; i < MIN_FRAME; i++) exp_q.push_back(8'h00);
        score_frame(len, bad);
        exp_len_q.push_back(lb < MIN_FRAME ? MIN_FRAME : lb);
        n_checks++; if (bad != 0 || cap_q.size() != len) $display("FAIL same_a_bytes mismatches=%0d len=%0d exp 0/%0d", bad, cap_q.size(), len); else n_pass++;
        n_checks++; if (tx_data_valid !== 1'b0) $display("FAIL same_a_end valid=%b exp=0", tx_data_valid); else n_pass++;
        exp_frames++;
        n_checks++; if (frames_sent !== 16'(exp_frames)) $display("FAIL same_a_frames got=%0d exp=%0d", frames_sent, exp_frames); else n_pass++;
        n = 0;
        while (tx_data_valid !== 1'b1 && n < 100) begin n++; @(negedge clk); end
        n_checks++; if (n != IFG + 2) $display("FAIL same_b_start low_cycles=%0d exp=%0d", n, IFG + 2); else n_pass++;
        collect(1);
        score_frame(len, bad);
        n_checks++; if (timed_out || bad != 0 || cap_q.size() != len) $display("FAIL same_b_bytes timeout=%0d mismatches=%0d len=%0d exp 0/0/%0d", timed_out, bad, cap_q.size(), len); else n_pass++;
        exp_frames++;
        n_checks++; if (frames_sent !== 16'(exp_frames)) $display("FAIL same_b_frames got=%0d exp=%0d", frames_sent, exp_frames); else n_pass++;
        n = 0;
        repeat (40) begin if (tx_data_valid !== 1'b0) n++; @(negedge clk); end
        n_checks++; if (n != 0 || count !== 10'd0) $display("FAIL same_no_extra high_cycles=%0d count=%0d exp 0/0", n, count); else n_pass++;
    endtask

    // Depth-16 instance, 20 writes without an end-of-frame flag.
    task automatic test_overflow();
        int m_cnt, bad, vhigh;
        bit m_ovf;
        m_cnt = 0; m_ovf = 0; bad = 0; vhigh = 0;
        for (int i = 0; i <= 20; i++) begin
            if (s_count !== 5'(m_cnt) || s_full !== (m_cnt == 16) || s_overflow !== m_ovf) bad++;
            if (s_tx_data_valid !== 1'b0) vhigh++;
            if (i == 16) begin
                n_checks++; if (s_full !== 1'b1 || s_count !== 5'd16) $display("FAIL ovf_full full=%b count=%0d exp 1/16", s_full, s_count); else n_pass++;
            end
            if (i == 17) begin
                n_checks++; if (s_count !== 5'd0 || s_overflow !== 1'b1) $display("FAIL ovf_flush count=%0d overflow=%b exp 0/1", s_count, s_overflow); else n_pass++;
            end
            s_wr_en = (i < 20); s_wr_data = 8'($urandom); s_wr_last = 1'b0;
            if (i < 20) begin
                if (m_cnt == 16) begin m_ovf = 1; m_cnt = 0; end
                else m_cnt++;
            end
            @(negedge clk);
        end
        s_wr_en = 1'b0;
        repeat (10) begin if (s_tx_data_valid !== 1'b0) vhigh++; @(negedge clk); end
        n_checks++; if (bad != 0) $display("FAIL ovf_track mismatching_cycles=%0d exp=0", bad); else n_pass++;
        n_checks++; if (s_count !== 5'(m_cnt) || s_overflow !== 1'b1) $display("FAIL ovf_final count=%0d overflow=%b exp %0d/1", s_count, s_overflow, m_cnt); else n_pass++;
        n_checks++; if (vhigh != 0) $display("FAIL ovf_no_valid high_cycles=%0d exp=0", vhigh); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int n;
        logic [7:0] b30;
        write_frame(64, 1'b0);
        write_frame(64, 1'b0);
        b30 = exp_q[30];
        n = 0;
        while (tx_data_valid !== 1'b1 && n < 100) begin n++; @(negedge clk); end
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        for (int k = 1; k < 30; k++) @(negedge clk);
        n_checks++; if (tx_data_valid !== 1'b1 || tx_data !== b30) $display("FAIL rst_byte30 valid=%b data=%h exp 1/%h", tx_data_valid, tx_data, b30); else n_pass++;
        tx_reset = 1'b1;
        @(negedge clk);
        tx_reset = 1'b0;
        exp_q.delete(); exp_len_q.delete(); exp_frames = 0;
        n_checks++; if (tx_data_valid !== 1'b0 || tx_data !== 8'h00) $display("FAIL rst_valid valid=%b data=%h exp 0/00", tx_data_valid, tx_data); else n_pass++;
        n_checks++; if (count !== 10'd0 || full !== 1'b0) $display("FAIL rst_count count=%0d full=%b exp 0/0", count, full); else n_pass++;
        n_checks++; if (frames_sent !== 16'(exp_frames)) $display("FAIL rst_frames got=%0d exp=%0d", frames_sent, exp_frames); else n_pass++;
        n = 0;
        repeat (200) begin if (tx_data_valid !== 1'b0) n++; tx_ack = 1'($urandom); @(negedge clk); end
        tx_ack = 1'b0;
        n_checks++; if (n != 0) $display("FAIL rst_silent high_cycles=%0d exp=0", n); else n_pass++;
    endtask

    initial begin
        tx_reset = 1'b1; wr_en = 1'b0; wr_last = 1'b0; wr_data = 8'h00; tx_ack = 1'b0;
        s_wr_en = 1'b0; s_wr_last = 1'b0; s_wr_data = 8'h00; s_tx_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_frame_64();
        test_short(10);
        test_short(1);
        test_back_to_back();
        test_same_cycle_last();
        test_overflow();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mac_tx_framer.md
# mac_tx_framer

Store-and-forward transmit buffer between the packetizer output and the Ethernet MAC transmitter client interface, all in the `tx_clk` domain. It buffers bytes tagged with an end-of-frame flag and starts a frame only once the whole frame is buffered, so the MAC never underruns. It drives the MAC valid/ack handshake, pads short frames to a minimum length, and enforces an inter-frame gap. This is the parametrised successor to the fixed-threshold FIFO drain state machine.

## Interface
- `DATA_W`, 8: payload width per word.
- `DEPTH_LOG2`, 9: FIFO depth is 2^DEPTH_LOG2 words; each word is DATA_W+1 bits (data plus last flag).
- `MIN_FRAME`, 60: minimum bytes per frame; shorter frames are zero-padded. 0 disables padding.
- `IFG`, 12: idle cycles forced after each frame, 0..255.
- `tx_clk` in 1: single clock.
- `tx_reset` in 1: reset. One clock; reset is synchronous and active-high.
- `wr_data` in DATA_W: write data.
- `wr_last` in 1: marks the final word of a frame.
- `wr_en` in 1: write strobe.
- `full` out 1: FIFO holds 2^DEPTH_LOG2 words.
- `count` out DEPTH_LOG2+1: words currently stored.
- `overflow` out 1: sticky error flag.
- `tx_data` out DATA_W: data to the MAC.
- `tx_data_valid` out 1: frame in progress.
- `tx_ack` in 1: MAC accepted the first byte.
- `frames_sent` out 16: completed frames, wraps modulo 2^16.

## Operation
- Reset values:
  - `count` = 0, `full` = 0, `overflow` = 0.
  - `tx_data` = 0, `tx_data_valid` = 0, `frames_sent` = 0.
  - State IDLE; pending-frame counter = 0.
  - FIFO contents are discarded.
- Write path:
  - A write is accepted when `wr_en` = 1 and `full` = 0.
  - A write while `full` = 1 is dropped and sets `overflow`, even if a pop occurs in the same cycle.
  - `overflow` stays set until reset.
- Pending counter:
  - Increments when a write with `wr_last` is accepted.
  - Decrements when a last-flagged word is popped.
  - Both in the same cycle: the counter is unchanged.
- Deadlock flush: if `full` = 1 and pending = 0 (frame larger than the FIFO), the block sets `overflow` and the FIFO is emptied next cycle. `count` = 0 and the state returns to IDLE.
- States:
  - IDLE: go to WAIT_ACK when pending != 0.
  - WAIT_ACK:
    - Drives `tx_data_valid` = 1 and `tx_data` = FIFO head, held stable.
    - On `tx_ack` = 1 the head is popped and the byte counter is set to 1.
    - If the head is flagged last, go to PAD (counter < MIN_FRAME) or GAP. Otherwise go to SEND.
  - SEND:
    - Pops one word per cycle and drives it on `tx_data` with `tx_data_valid` = 1; the byte counter increments.
    - On popping the last-flagged word, go to PAD if counter+1 < MIN_FRAME, else GAP.
  - PAD: `tx_data_valid` = 1, `tx_data` = 0, counter increments; go to GAP when the counter reaches MIN_FRAME.
  - GAP:
    - `tx_data_valid` = 0; `frames_sent` increments on entry.
    - Counts IFG cycles, then goes to IDLE. IFG = 0 means a single-cycle GAP.
- `tx_ack` is ignored outside WAIT_ACK.
- The byte counter is 16 bits and saturates at 0xFFFF.
- `tx_data` = 0 whenever `tx_data_valid` = 0.
- Reset mid-frame: the next cycle has `tx_data_valid` = 0 and all state as listed under reset values; the partial frame is lost.

## Timing
- The FIFO is first-word-fall-through: the head is visible on `tx_data` in the same cycle WAIT_ACK is entered.
- Frame start latency: the last word of a frame is written at cycle N. Pending becomes 1 at N+1. WAIT_ACK and `tx_data_valid` begin at N+2 (when IDLE).
- Byte 0 is accepted in the `tx_ack` cycle. Byte k appears at ack cycle + k.
- `tx_data_valid` is high from WAIT_ACK entry through the final byte or pad cycle. It is low on the first GAP cycle.
- Back-to-back frames are separated by IFG+1 cycles with `tx_data_valid` low, plus 1 IDLE cycle.
- `count` and `full` are registered and reflect writes and pops of the previous cycle.

## Test plan
- 64-byte frame 0x00..0x3F written, `tx_ack` 3 cycles after valid rises -> `tx_data` holds 0x00 until ack. Then 0x01..0x3F on consecutive cycles. Valid is low for 13 cycles after the frame; `frames_sent` = 1.
- 10-byte frame with MIN_FRAME = 60 -> 10 data bytes followed by 50 bytes of 0x00, 60 valid cycles after ack inclusive.
- 1-byte frame (`wr_last` on the first write) -> one byte on ack, then 59 pad bytes, then GAP.
- DEPTH_LOG2 = 4, 20 writes without `wr_last` -> `full` after 16 writes, `overflow` = 1. The flush leaves `count` = 0 and `tx_data_valid` never rises.
- Two 64-byte frames queued, then `tx_reset` pulsed at byte 30 of frame 1 -> valid low the next cycle, `count` = 0, `frames_sent` = 0, no further output.
- Write with `wr_last` in the same cycle as popping another frame's last word -> pending unchanged and the second frame starts after GAP.
